// File: rtl/uart_tx_bridge.sv
// Byte FIFO feeding an 8N1 UART transmitter; the core pushes bytes with uart_we,
// and the FSM drains them back-to-back with no idle gap between frames.
module uart_tx_bridge #(
    parameter int CLK_DIV   = 868,
    parameter int FIFO_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_we,
    input  logic [31:0]          uart_dout,
    output logic                 txd,
    output logic                 busy,
    output logic [FIFO_LOG2:0]   fifo_count,
    output logic                 overflow
);
    localparam int DEPTH = 2 ** FIFO_LOG2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [15:0]          BAUD_LAST  = 16'(CLK_DIV - 1);
    localparam logic [FIFO_LOG2:0]   FULL_COUNT = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_LOG2:0]   CNT_ONE    = (FIFO_LOG2 + 1)'(1);
    localparam logic [FIFO_LOG2-1:0] PTR_ONE    = FIFO_LOG2'(1);

    logic [7:0]           mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic [1:0]           state;
    logic [15:0]          baud_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shift;
    logic                 baud_last;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 push;
    logic                 unused_dout_hi;

    assign unused_dout_hi = ^uart_dout[31:8];

    assign baud_last  = (baud_cnt == BAUD_LAST);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_COUNT);
    // The FSM takes the head byte either from idle or on the last stop-bit cycle.
    assign pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_last));
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign push = uart_we && (!fifo_full || pop);
    assign busy = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: ;
            endcase
            if (uart_we && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= uart_dout[7:0];
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            shift <= mem[rd_ptr];
        end else if ((state == DATA) && baud_last) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

    // txd is loaded with the level of the state being entered, so it is a pure flop output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= 1'b1;
        end else begin
            baud_cnt <= baud_last ? '0 : baud_cnt + 16'd1;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        state <= START;
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        txd     <= shift[0];
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        if (pop) begin
                            state <= START;
                            txd   <= 1'b0;
                        end else begin
                            state <= IDLE;
                            txd   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_bridge.sv
// Directed bench for uart_tx_bridge: a serial monitor decodes txd and checks each
// frame against a queue of bytes recorded when they were pushed.
`timescale 1ns/1ps
module tb_uart_tx_bridge;
    localparam int CLK_DIV   = 4;
    localparam int FIFO_LOG2 = 2;
    localparam int FRAME     = 10 * CLK_DIV;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 uart_we;
    logic [31:0]          uart_dout;
    logic                 txd;
    logic                 busy;
    logic [FIFO_LOG2:0]   fifo_count;
    logic                 overflow;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic       rst_seen = 1'b1;
    logic [7:0] exp_q[$];
    int         frame_starts[$];
    int         frames_done = 0;
    logic       mon_active = 1'b0;
    int         mon_t = 0;
    logic [7:0] mon_byte = '0;

    uart_tx_bridge #(.CLK_DIV(CLK_DIV), .FIFO_LOG2(FIFO_LOG2)) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_we    (uart_we),
        .uart_dout  (uart_dout),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input string tag, input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(frames_done), 32'(target));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // Serial receiver: samples mid-bit, aborts on reset, scores each completed frame.
    initial forever begin
        @(negedge clk);
        if (rst_seen) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (txd === 1'b0) begin
                mon_active = 1'b1;
                mon_t      = 0;
                mon_byte   = '0;
                frame_starts.push_back(cyc);
            end
        end else begin
            mon_t++;
            if (mon_t == CLK_DIV / 2) check("mon_start_bit", 32'(txd), 32'd0);
            if (mon_t >= CLK_DIV && mon_t < 9 * CLK_DIV && (mon_t % CLK_DIV) == CLK_DIV / 2)
                mon_byte[mon_t / CLK_DIV - 1] = txd;
            if (mon_t == 9 * CLK_DIV + CLK_DIV / 2) begin
                check("mon_stop_bit", 32'(txd), 32'd1);
                check("mon_frame_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("mon_frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                frames_done++;
            end
            if (mon_t == FRAME - 1) mon_active = 1'b0;
        end
    end

    initial begin
        #400us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] wave;
        logic [7:0] b;
        int base;
        int low_seen;
        int n;
        int exp_cnt [6];
        int exp_ovf [6];

        reset = 1'b1;
        uart_we = 1'b0;
        uart_dout = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // reset wins over a simultaneous push
        reset = 1'b1;
        uart_we = 1'b1;
        uart_dout = 32'h0000_0077;
        @(negedge clk);
        reset = 1'b0;
        uart_we = 1'b0;
        check("rstwe_count", 32'(fifo_count), 32'd0);
        check("rstwe_busy", 32'(busy), 32'd0);
        repeat (8) @(negedge clk);
        check("rstwe_txd_idle", 32'(txd), 32'd1);
        check("rstwe_no_frame", 32'(frames_done), 32'd0);

        // single frame of 0xA5, checked cycle by cycle
        uart_we = 1'b1;
        uart_dout = 32'h0000_00A5;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        uart_we = 1'b0;
        check("a5_count_after_push", 32'(fifo_count), 32'd1);
        check("a5_txd_before_pop", 32'(txd), 32'd1);
        check("a5_busy", 32'(busy), 32'd1);
        wave = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            check("a5_txd_wave", 32'(txd), 32'(wave[i / CLK_DIV]));
            if (i == 0) check("a5_popped", 32'(fifo_count), 32'd0);
        end
        check("a5_busy_last_stop", 32'(busy), 32'd1);
        @(negedge clk);
        check("a5_busy_fall", 32'(busy), 32'd0);
        check("a5_txd_idle", 32'(txd), 32'd1);
        check("a5_frames", 32'(frames_done), 32'd1);

        // three back-to-back frames
        repeat (5) @(negedge clk);
        base = frames_done;
        for (int i = 0; i < 3; i++) begin
            b = 8'((i + 1) * 17);
            uart_we = 1'b1;
            uart_dout = {24'h0, b};
            exp_q.push_back(b);
            @(negedge clk);
        end
        uart_we = 1'b0;
        wait_frames("seq3_frames", base + 3, 4 * FRAME);
        if (frame_starts.size() >= base + 3) begin
            check("seq3_gap01", 32'(frame_starts[base + 1] - frame_starts[base]), 32'(FRAME));
            check("seq3_gap12", 32'(frame_starts[base + 2] - frame_starts[base + 1]), 32'(FRAME));
        end
        wait_idle("seq3_idle", 20);

        // six pushes from idle: one pop on the second edge, four queued, one dropped
        exp_cnt = '{1, 1, 2, 3, 4, 4};
        exp_ovf = '{0, 0, 0, 0, 0, 1};
        base = frames_done;
        for (int i = 0; i < 6; i++) begin
            uart_we = 1'b1;
            uart_dout = 32'h0000_0001 + 32'(i);
            if (i < 5) exp_q.push_back(8'(i + 1));
            @(negedge clk);
            check("ovf_count", 32'(fifo_count), 32'(exp_cnt[i]));
            check("ovf_flag", 32'(overflow), 32'(exp_ovf[i]));
        end
        uart_we = 1'b0;
        wait_frames("ovf_frames", base + 5, 6 * FRAME);
        wait_idle("ovf_idle", 20);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // full FIFO push coinciding with the stop-final pop
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("full_rst_overflow", 32'(overflow), 32'd0);
        base = frames_done;
        for (int i = 0; i < 5; i++) begin
            uart_we = 1'b1;
            uart_dout = 32'h0000_0040 + 32'(i);
            exp_q.push_back(8'(8'h40 + i));
            @(negedge clk);
        end
        uart_we = 1'b0;
        check("full_count", 32'(fifo_count), 32'd4);
        repeat (36) @(negedge clk);
        check("full_before_stop", 32'(fifo_count), 32'd4);
        check("full_in_stop_txd", 32'(txd), 32'd1);
        uart_we = 1'b1;
        uart_dout = 32'h0000_0066;
        exp_q.push_back(8'h66);
        @(negedge clk);
        uart_we = 1'b0;
        check("full_pushpop_count", 32'(fifo_count), 32'd4);
        check("full_pushpop_ovf", 32'(overflow), 32'd0);
        check("full_next_start", 32'(txd), 32'd0);
        wait_frames("full_frames", base + 6, 7 * FRAME);
        wait_idle("full_idle", 20);
        check("full_ovf_final", 32'(overflow), 32'd0);

        // reset during data bit 3 with two bytes queued
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'h2A : ((i == 1) ? 8'h5A : 8'h96);
            uart_we = 1'b1;
            uart_dout = {24'h0, b};
            exp_q.push_back(b);
            @(negedge clk);
        end
        uart_we = 1'b0;
        check("abort_queued", 32'(fifo_count), 32'd2);
        repeat (16) @(negedge clk);
        check("abort_bit3", 32'(txd), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("abort_txd", 32'(txd), 32'd1);
        check("abort_count", 32'(fifo_count), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        base = frames_done;
        low_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (txd !== 1'b1) low_seen++;
        end
        check("abort_no_txd_low", 32'(low_seen), 32'd0);
        check("abort_no_frames", 32'(frames_done), 32'(base));

        // ten paced pushes wrapping the pointers, upper bits ignored
        base = frames_done;
        for (int i = 0; i < 10; i++) begin
            n = 0;
            while (fifo_count == 3'd4 && n < 200) begin
                @(negedge clk);
                n++;
            end
            b = 8'(i * 37 + 11);
            uart_we = 1'b1;
            uart_dout = {24'hDEADBE, b};
            exp_q.push_back(b);
            @(negedge clk);
            uart_we = 1'b0;
        end
        wait_frames("wrap_frames", base + 10, 12 * FRAME);
        wait_idle("wrap_idle", 20);
        check("wrap_queue_drained", 32'(exp_q.size()), 32'd0);
        check("wrap_overflow", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_bridge.md
UART_TX_BRIDGE -- requirements
Module: uart_tx_bridge

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 868, giving clock cycles per UART bit time; legal range 2..65535.
REQ-002 The block SHALL have parameter FIFO_LOG2, default 4, giving a byte FIFO depth of 2**FIFO_LOG2 entries.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port uart_we, input, 1 bit: byte-push strobe from the core's memory stage.
REQ-006 The block SHALL have port uart_dout, input, 32 bits: push data; only bits [7:0] are transmitted and bits [31:8] are ignored.
REQ-007 The block SHALL have port txd, output, 1 bit: serial line, 8N1, LSB first, idle high.
REQ-008 The block SHALL have port busy, output, 1 bit: high while the FIFO is non-empty or a frame is in progress.
REQ-009 The block SHALL have port fifo_count, output, FIFO_LOG2+1 bits: current FIFO occupancy.
REQ-010 The block SHALL have port overflow, output, 1 bit: sticky flag set when a push is dropped.

Function
REQ-011 When uart_we is high at an edge and the FIFO is not full, the block SHALL push uart_dout[7:0]; fifo_count SHALL reflect the push after that edge.
REQ-012 When uart_we is high at an edge, the FIFO is full, and no pop occurs at the same edge, the block SHALL drop the byte and set overflow; overflow SHALL stay high until reset.
REQ-013 When a push and a pop occur at the same edge, both SHALL take effect (count unchanged), including the full case, in which the push SHALL NOT be dropped.
REQ-014 The FIFO SHALL be first-in first-out, with read and write pointers wrapping modulo 2**FIFO_LOG2 and no byte reordered or duplicated across the wrap.
REQ-015 The transmit FSM SHALL have states IDLE, START, DATA and STOP.
REQ-016 IDLE: txd=1; if fifo_count != 0 at an edge, the FSM SHALL pop the head byte into an 8-bit shift register and enter START.
REQ-017 START: txd=0 for exactly CLK_DIV cycles, then enter DATA with the bit index at 0.
REQ-018 DATA: txd=shift[0] for CLK_DIV cycles per bit, shifting right after each bit, and enter STOP after bit 7.
REQ-019 STOP: txd=1 for CLK_DIV cycles; at its final cycle the FSM SHALL pop and enter START if the FIFO is non-empty, else enter IDLE, so that back-to-back frames are exactly 10*CLK_DIV cycles apart with no idle gap.
REQ-020 The baud counter SHALL count 0..CLK_DIV-1 and reload to 0 on every state or bit transition; no fractional accumulation.
REQ-021 txd SHALL be driven directly from a flip-flop (glitch-free).
REQ-022 Latency: for a push at edge k into an empty FIFO with the FSM in IDLE, the pop SHALL occur at edge k+1 and txd SHALL fall after edge k+1.
REQ-023 busy SHALL equal (state != IDLE) OR (fifo_count != 0), combinationally from registered state.
REQ-024 The maximum occupancy 2**FIFO_LOG2 SHALL be representable in fifo_count without wrapping to 0.

Reset
REQ-025 On reset the block SHALL set txd=1, state=IDLE, baud counter=0, FIFO pointers=0, fifo_count=0, overflow=0 and busy=0, effective after the reset edge.
REQ-026 Reset asserted mid-frame SHALL abort the frame (txd high after the reset edge) and discard all queued bytes.
REQ-027 Reset SHALL take priority over a simultaneous uart_we, and that byte SHALL be discarded.

Verification (CLK_DIV=4, FIFO_LOG2=2)
REQ-028 The bench SHALL cover a single push of 0x000000A5 into an idle block -> txd low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; busy falls after 40 cycles.
REQ-029 The bench SHALL cover three consecutive pushes 0x11, 0x22, 0x33 -> three frames contiguous over 120 cycles, stop-to-start with no idle cycle, bytes in order.
REQ-030 The bench SHALL cover pushing 6 bytes on consecutive cycles from idle -> first byte popped at cycle 2, 4 queued, 1 dropped, overflow=1 and held.
REQ-031 The bench SHALL cover a push while full, coinciding with the STOP-final pop -> byte accepted, fifo_count stays 4, overflow stays 0.
REQ-032 The bench SHALL cover reset asserted during DATA bit 3 with 2 bytes queued -> after the edge txd=1, fifo_count=0, busy=0, and no further frames.
REQ-033 The bench SHALL cover 10 pushes across pointer wrap with upper bits 0xDEADBE -> received byte stream matches the low bytes exactly.
